// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the TX frame serializer.
// Character = start bit, 8 data bits LSB first, stop bit.
package tx_frame_pkg;

    typedef enum logic [1:0] {IDLE, PRE, LEN, DATA} tx_state_t;

    localparam int          CHAR_BITS     = 10;
    localparam logic        START_BIT     = 1'b0;
    localparam logic        STOP_BIT      = 1'b1;
    localparam int unsigned MAX_FRAME_LEN = 255;

    // Bit 0 goes on the line first.
    function automatic logic [CHAR_BITS-1:0] make_char(input logic [7:0] b);
        return {STOP_BIT, b, START_BIT};
    endfunction

    function automatic logic [7:0] clamp_len(input int unsigned lvl);
        return (lvl > MAX_FRAME_LEN) ? 8'(MAX_FRAME_LEN) : 8'(lvl);
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Single-clock byte FIFO, show-ahead: dout always presents the oldest entry.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module tx_byte_fifo #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_serializer.sv
// Buffers driver bytes and serialises PREAMBLE, LENGTH, then LENGTH payload
// bytes as 8N1 characters on tx_bit, BIT_PERIOD clocks per bit.
module tx_frame_serializer
    import tx_frame_pkg::*;
#(
    parameter int          FIFO_DEPTH = 256,
    parameter int          BIT_PERIOD = 50,
    parameter logic [7:0]  PREAMBLE   = 8'hA5,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1,
    localparam int         CW         = $clog2(BIT_PERIOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    data_tx,
    input  logic          wren_fifo_tx,
    input  logic          start_tx,
    output logic          ready_tx,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          tx_bit,
    output logic          tx_active,
    output logic          frame_done
);

    tx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_idx_q;
    logic [7:0]           byte_cnt_q, len_q, len_d;
    logic [CHAR_BITS-1:0] shift_q;
    logic                 ready_q, active_q, done_q, ovf_q;

    logic       fifo_full, fifo_empty, pop, char_end, start_ok, drop;
    logic [7:0] fifo_dout;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wren_fifo_tx),
        .din   (data_tx),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign char_end = (state_q != IDLE) && (cnt_q == CW'(BIT_PERIOD - 1))
                      && (bit_idx_q == 4'(CHAR_BITS - 1));
    // The pop lands on the edge that loads the payload character.
    assign pop      = char_end && ((state_q == LEN) ||
                                   (state_q == DATA && byte_cnt_q != len_q));
    assign start_ok = (state_q == IDLE) && start_tx && !fifo_empty;
    assign drop     = wren_fifo_tx && fifo_full && !pop;
    assign len_d    = clamp_len(32'(fifo_level));

    assign ready_tx   = ready_q;
    assign tx_active  = active_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign tx_bit     = shift_q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            shift_q    <= '1;
            ready_q    <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A drop in the accepting cycle still leaves the flag set.
            if (start_ok) ovf_q <= 1'b0;
            if (drop)     ovf_q <= 1'b1;

            if (state_q == IDLE) begin
                if (start_ok) begin
                    state_q    <= PRE;
                    len_q      <= len_d;
                    shift_q    <= make_char(PREAMBLE);
                    cnt_q      <= '0;
                    bit_idx_q  <= '0;
                    byte_cnt_q <= '0;
                    ready_q    <= 1'b0;
                    active_q   <= 1'b1;
                end
            end else if (cnt_q != CW'(BIT_PERIOD - 1)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
                if (!char_end) begin
                    bit_idx_q <= bit_idx_q + 1'b1;
                    shift_q   <= {STOP_BIT, shift_q[CHAR_BITS-1:1]};
                end else begin
                    bit_idx_q <= '0;
                    case (state_q)
                        PRE: begin
                            state_q <= LEN;
                            shift_q <= make_char(len_q);
                        end
                        LEN: begin
                            state_q    <= DATA;
                            shift_q    <= make_char(fifo_dout);
                            byte_cnt_q <= 8'd1;
                        end
                        DATA: begin
                            if (byte_cnt_q != len_q) begin
                                shift_q    <= make_char(fifo_dout);
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end else begin
                                state_q  <= IDLE;
                                shift_q  <= '1;
                                ready_q  <= 1'b1;
                                active_q <= 1'b0;
                                done_q   <= 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: idle/enqueue vector table, then
// full frames checked bit by bit against a reference byte queue.
module tb_tx_frame_serializer;

    localparam int BP    = 4;
    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_tx = '0;
    logic       wren_fifo_tx = 1'b0;
    logic       start_tx = 1'b0;
    logic       ready_tx, overflow, tx_bit, tx_active, frame_done;
    logic [8:0] fifo_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] model[$];

    tx_frame_serializer #(.FIFO_DEPTH(DEPTH), .BIT_PERIOD(BP), .PREAMBLE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_tx      (data_tx),
        .wren_fifo_tx (wren_fifo_tx),
        .start_tx     (start_tx),
        .ready_tx     (ready_tx),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .tx_bit       (tx_bit),
        .tx_active    (tx_active),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wren;
        logic [7:0] din;
        logic       start;
        int         lvl;
        logic       rdy;
        logic       txb;
        logic       ovf;
        logic       done;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wren_fifo_tx = 1'b1;
        data_tx      = d;
        if (model.size() < DEPTH) model.push_back(d);
        @(negedge clk);
        wren_fifo_tx = 1'b0;
    endtask

    // Starts a frame from IDLE and checks every line cycle. Optional actions:
    // start pulse at cycle start_at, n_wr writes from cycle wr_at, level probe at chk_at.
    task automatic run_frame(input int start_at, input int wr_at, input int n_wr,
                             input logic [7:0] wbase, input int chk_at, input int chk_lvl);
        logic [7:0] exp[$];
        logic [7:0] ch;
        logic       eb;
        int len, n, bad, idx, c, b;
        len = (model.size() > 255) ? 255 : model.size();
        exp.push_back(8'hA5);
        exp.push_back(8'(len));
        for (int i = 0; i < len; i++) exp.push_back(model.pop_front());
        n   = (len + 2) * 10 * BP;
        bad = 0;
        start_tx = 1'b1;
        @(negedge clk);
        start_tx = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = k - 1;
            c   = idx / (10 * BP);
            b   = (idx / BP) % 10;
            ch  = exp[c];
            eb  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
            if (tx_bit !== eb || ready_tx !== 1'b0 || tx_active !== 1'b1 || frame_done !== 1'b0)
                bad++;
            if (k == 1) check("ovf_clear_on_start", int'(overflow), 0);
            if (k == chk_at) begin
                check("level_push_pop_full", int'(fifo_level), chk_lvl);
                check("ovf_push_pop_full", int'(overflow), 0);
            end
            wren_fifo_tx = (k >= wr_at) && (k < wr_at + n_wr);
            if (wren_fifo_tx) begin
                data_tx = wbase + 8'(k - wr_at);
                model.push_back(data_tx);
            end
            start_tx = (start_at != 0) && (k == start_at);
            @(negedge clk);
        end
        wren_fifo_tx = 1'b0;
        start_tx     = 1'b0;
        check("line_bad_cycles", bad, 0);
        check("done_pulse", int'(frame_done), 1);
        check("ready_at_done", int'(ready_tx), 1);
        check("active_at_done", int'(tx_active), 0);
        check("txbit_at_done", int'(tx_bit), 1);
        @(negedge clk);
        check("done_one_cycle", int'(frame_done), 0);
        check("level_after_frame", int'(fifo_level), model.size());
    endtask

    initial begin
        vec_t tbl[7];
        int bad;
        tbl[0] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0};  // start on empty FIFO
        tbl[2] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h02, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h03, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready_tx), 1);
        check("rst_txbit", int'(tx_bit), 1);
        check("rst_active", int'(tx_active), 0);
        check("rst_level", int'(fifo_level), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            wren_fifo_tx = tbl[i].wren;
            data_tx      = tbl[i].din;
            start_tx     = tbl[i].start;
            if (tbl[i].wren) model.push_back(tbl[i].din);
            @(negedge clk);
            check($sformatf("v%0d_level", i), int'(fifo_level), tbl[i].lvl);
            check($sformatf("v%0d_ready", i), int'(ready_tx), int'(tbl[i].rdy));
            check($sformatf("v%0d_txbit", i), int'(tx_bit), int'(tbl[i].txb));
            check($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
            check($sformatf("v%0d_done", i), int'(frame_done), int'(tbl[i].done));
        end
        wren_fifo_tx = 1'b0;
        start_tx     = 1'b0;

        // A5,03,01,02,03 over 200 cycles
        run_frame(0, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 257; i++) wr(8'(i));
        check("level_full", int'(fifo_level), 256);
        check("ovf_set", int'(overflow), 1);
        run_frame(0, 0, 0, 8'h00, 0, 0);

        // Refill to full, then push on the edge of the first payload pop.
        for (int i = 0; i < 255; i++) wr(8'(i) ^ 8'h5A);
        check("level_refull", int'(fifo_level), 256);
        check("ovf_no_drop", int'(overflow), 0);
        run_frame(0, 80, 1, 8'hEE, 81, 256);

        // Busy start pulse ignored; five writes during DATA stay queued.
        run_frame(50, 90, 5, 8'h30, 0, 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (ready_tx !== 1'b1 || tx_bit !== 1'b1 || frame_done !== 1'b0 || tx_active !== 1'b0) bad++;
            @(negedge clk);
        end
        check("no_second_frame", bad, 0);
        check("level_five_new", int'(fifo_level), 5);

        // Reset in the middle of a payload character.
        start_tx = 1'b1;
        @(negedge clk);
        start_tx = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_txbit", int'(tx_bit), 1);
        check("abort_ready", int'(ready_tx), 1);
        check("abort_level", int'(fifo_level), 0);
        check("abort_done", int'(frame_done), 0);
        check("abort_active", int'(tx_active), 0);
        reset = 1'b0;
        model.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || tx_bit !== 1'b1) bad++;
        end
        check("abort_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
